// File: rtl/mem_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_ctrl
// Purpose  : Byte-wide memory controller and arbiter. Serves one-byte reads
//            from the instruction cache (I side) and one-byte reads/writes
//            from the data side (D side) over a single synchronous byte
//            RAM/IO port. It honours branch flushes for the I side and stalls
//            IO-space writes while the IO write buffer is full.
// Ports    : clk, rst (async, active-low)
//            branch_error                      - flush of the I side
//            if_request_i/if_addr_i            - I side request
//            if_data_o/if_done_o               - I side response
//            mem_request_i/mem_wr_i/mem_addr_i/
//            mem_data_i                        - D side request
//            mem_data_o/mem_done_o             - D side response
//            ram_addr_o/ram_wr_o/ram_dout_o    - RAM command (registered)
//            ram_din_i                         - RAM read data
//            io_buffer_full_i                  - IO write buffer full
// Revision : 1.0 - initial release
// ============================================================================
module mem_ctrl #(
  parameter int unsigned       ADDR_W  = 32,
  parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(32'h0003_0000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              branch_error,
  input  logic              if_request_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [7:0]        if_data_o,
  output logic              if_done_o,
  input  logic              mem_request_i,
  input  logic              mem_wr_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [7:0]        mem_data_i,
  output logic [7:0]        mem_data_o,
  output logic              mem_done_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_wr_o,
  output logic [7:0]        ram_dout_o,
  input  logic [7:0]        ram_din_i,
  input  logic              io_buffer_full_i
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic              owner_d, owner_d_nxt;   // 1: D side owns the slot
  logic              last_d, last_d_nxt;     // 1: last grant went to D
  logic              op_wr, op_wr_nxt;       // slot carries a D write
  logic [ADDR_W-1:0] ram_addr_nxt;
  logic              ram_wr_nxt;
  logic [7:0]        ram_dout_nxt;
  logic [7:0]        if_data_nxt, mem_data_nxt;
  logic              if_done_nxt, mem_done_nxt;

  logic              d_cand, i_cand, grant_d, i_flush;

  // An IO-space write cannot be accepted while the IO buffer is full; the
  // request simply stays pending until the buffer drains.
  assign d_cand  = mem_request_i &&
                   !(mem_wr_i && (mem_addr_i >= IO_BASE) && io_buffer_full_i);
  assign i_cand  = if_request_i && !branch_error;
  // Round-robin: on contention, the side that did not win last time wins.
  assign grant_d = d_cand && (!i_cand || !last_d);
  assign i_flush = !owner_d && branch_error;

  always_comb begin
    state_nxt    = state;
    owner_d_nxt  = owner_d;
    last_d_nxt   = last_d;
    op_wr_nxt    = op_wr;
    ram_addr_nxt = ram_addr_o;
    ram_wr_nxt   = 1'b0;
    ram_dout_nxt = ram_dout_o;
    if_data_nxt  = if_data_o;
    mem_data_nxt = mem_data_o;
    if_done_nxt  = 1'b0;
    mem_done_nxt = 1'b0;

    case (state)
      ST_IDLE: begin
        if (d_cand || i_cand) begin
          state_nxt    = ST_ISSUE;
          owner_d_nxt  = grant_d;
          last_d_nxt   = grant_d;
          op_wr_nxt    = grant_d && mem_wr_i;
          ram_addr_nxt = grant_d ? mem_addr_i : if_addr_i;
          ram_wr_nxt   = grant_d && mem_wr_i;
          if (grant_d && mem_wr_i) begin
            ram_dout_nxt = mem_data_i;
          end
        end
      end
      ST_ISSUE: begin
        // RAM samples the command on this edge; the strobe drops afterwards.
        state_nxt = i_flush ? ST_DONE : ST_WAIT;
      end
      ST_WAIT: begin
        state_nxt = ST_DONE;
        if (owner_d) begin
          mem_done_nxt = 1'b1;
          if (!op_wr) begin
            mem_data_nxt = ram_din_i;
          end
        end else if (!branch_error) begin
          if_done_nxt = 1'b1;
          if_data_nxt = ram_din_i;
        end
      end
      ST_DONE: begin
        // Spare cycle so the requester can advance before re-arbitration.
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      owner_d    <= 1'b0;
      last_d     <= 1'b0;
      op_wr      <= 1'b0;
      ram_addr_o <= '0;
      ram_wr_o   <= 1'b0;
      ram_dout_o <= 8'h00;
      if_data_o  <= 8'h00;
      mem_data_o <= 8'h00;
      if_done_o  <= 1'b0;
      mem_done_o <= 1'b0;
    end else begin
      state      <= state_nxt;
      owner_d    <= owner_d_nxt;
      last_d     <= last_d_nxt;
      op_wr      <= op_wr_nxt;
      ram_addr_o <= ram_addr_nxt;
      ram_wr_o   <= ram_wr_nxt;
      ram_dout_o <= ram_dout_nxt;
      if_data_o  <= if_data_nxt;
      mem_data_o <= mem_data_nxt;
      if_done_o  <= if_done_nxt;
      mem_done_o <= mem_done_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mem_ctrl
// Purpose  : Self-checking bench for mem_ctrl. A byte RAM model answers the
//            RAM port; a slot-timeline reference model predicts every output
//            cycle by cycle from the arbitration rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl;

  localparam int          ADDR_W  = 32;
  localparam logic [31:0] IO_BASE = 32'h0003_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        branch_error = 1'b0;
  logic        if_request_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic [7:0]  if_data_o;
  logic        if_done_o;
  logic        mem_request_i = 1'b0;
  logic        mem_wr_i = 1'b0;
  logic [31:0] mem_addr_i = '0;
  logic [7:0]  mem_data_i = '0;
  logic [7:0]  mem_data_o;
  logic        mem_done_o;
  logic [31:0] ram_addr_o;
  logic        ram_wr_o;
  logic [7:0]  ram_dout_o;
  logic [7:0]  ram_din;
  logic        io_buffer_full_i = 1'b0;

  mem_ctrl #(.ADDR_W(ADDR_W), .IO_BASE(IO_BASE)) dut (
    .clk              (clk),
    .rst              (rst),
    .branch_error     (branch_error),
    .if_request_i     (if_request_i),
    .if_addr_i        (if_addr_i),
    .if_data_o        (if_data_o),
    .if_done_o        (if_done_o),
    .mem_request_i    (mem_request_i),
    .mem_wr_i         (mem_wr_i),
    .mem_addr_i       (mem_addr_i),
    .mem_data_i       (mem_data_i),
    .mem_data_o       (mem_data_o),
    .mem_done_o       (mem_done_o),
    .ram_addr_o       (ram_addr_o),
    .ram_wr_o         (ram_wr_o),
    .ram_dout_o       (ram_dout_o),
    .ram_din_i        (ram_din),
    .io_buffer_full_i (io_buffer_full_i)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Compact RAM index covering every address the bench touches.
  function automatic int ridx(input logic [31:0] a);
    return {20'd0, a[17:16], a[9:0]};
  endfunction

  function automatic logic [7:0] init_val(input int i);
    if (i == 32'h100) return 8'h13;
    if (i == 32'h200) return 8'h5A;
    return 8'(i * 29 + 7);
  endfunction

  // Synchronous byte RAM: address sampled on an edge, data out after it.
  logic [7:0] ram [4096];
  bit         ram_ready = 1'b0;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 4096; i++) ram[i] <= init_val(i);
      ram_ready <= 1'b1;
    end else if (ram_wr_o) begin
      ram[ridx(ram_addr_o)] <= ram_dout_o;
    end
    ram_din <= ram[ridx(ram_addr_o)];
  end

  // ---------------- reference model (slot timeline) ----------------
  // A grant at edge t occupies the port until edge t+4; the RAM reads/writes
  // at t+1 and the requester sees completion after t+2. A flush at t+1 or
  // t+2 cancels an I completion; a flush at t+1 frees the port at t+3.
  logic [7:0]  ref_mem [4096];
  int          g_t, free_at;
  bit          g_d, g_wr, g_abort, last_d;
  logic [31:0] g_addr;
  logic [7:0]  g_wdata;
  logic [31:0] e_ram_addr;
  logic        e_ram_wr, e_if_done, e_mem_done;
  logic [7:0]  e_ram_dout, e_if_data, e_mem_data;

  task automatic model_reset();
    g_t = -100; free_at = 0; last_d = 1'b0; g_abort = 1'b0;
    g_d = 1'b0; g_wr = 1'b0; g_addr = '0; g_wdata = '0;
    e_ram_addr = '0; e_ram_wr = 1'b0; e_ram_dout = '0;
    e_if_done = 1'b0; e_mem_done = 1'b0; e_if_data = '0; e_mem_data = '0;
  endtask

  task automatic model_edge();
    int k;
    bit d_ok, i_ok, pick_d;
    e_ram_wr = 1'b0; e_if_done = 1'b0; e_mem_done = 1'b0;
    if (!rst) begin
      model_reset();
      return;
    end
    if (cyc < free_at) begin
      k = cyc - g_t;
      if (!g_d && !g_abort && (k == 1 || k == 2) && branch_error) begin
        g_abort = 1'b1;
        if (k == 1) free_at = g_t + 3;
      end
      if (k == 1 && g_wr) ref_mem[ridx(g_addr)] = g_wdata;
      if (k == 2 && !g_abort) begin
        if (g_d) begin
          e_mem_done = 1'b1;
          if (!g_wr) e_mem_data = ref_mem[ridx(g_addr)];
        end else begin
          e_if_done = 1'b1;
          e_if_data = ref_mem[ridx(g_addr)];
        end
      end
    end else begin
      d_ok = mem_request_i && !(mem_wr_i && mem_addr_i >= IO_BASE && io_buffer_full_i);
      i_ok = if_request_i && !branch_error;
      if (d_ok || i_ok) begin
        pick_d  = (d_ok && i_ok) ? !last_d : d_ok;
        last_d  = pick_d;
        g_t     = cyc;
        free_at = cyc + 4;
        g_d     = pick_d;
        g_abort = 1'b0;
        g_wr    = pick_d && mem_wr_i;
        g_addr  = pick_d ? mem_addr_i : if_addr_i;
        g_wdata = mem_data_i;
        e_ram_addr = g_addr;
        e_ram_wr   = g_wr;
        if (g_wr) e_ram_dout = g_wdata;
      end
    end
  endtask

  task automatic compare();
    check_eq("ram_wr",   32'(ram_wr_o),   32'(e_ram_wr));
    check_eq("ram_addr", ram_addr_o,      e_ram_addr);
    if (e_ram_wr) check_eq("ram_dout", 32'(ram_dout_o), 32'(e_ram_dout));
    check_eq("if_done",  32'(if_done_o),  32'(e_if_done));
    check_eq("mem_done", 32'(mem_done_o), 32'(e_mem_done));
    check_eq("if_data",  32'(if_data_o),  32'(e_if_data));
    check_eq("mem_data", 32'(mem_data_o), 32'(e_mem_data));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    model_edge();
    compare();
  endtask

  task automatic wait_done(input bit want_d, input int max, output int waited);
    waited = 0;
    do begin
      step();
      waited++;
    end while (!(want_d ? mem_done_o : if_done_o) && waited < max);
    check_eq(want_d ? "mem_done_seen" : "if_done_seen",
             32'(want_d ? mem_done_o : if_done_o), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int pulses;
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(i);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ram_wr",   32'(ram_wr_o),   32'd0);
    check_eq("rst_ram_addr", ram_addr_o,      32'd0);
    check_eq("rst_ram_dout", 32'(ram_dout_o), 32'd0);
    check_eq("rst_if_done",  32'(if_done_o),  32'd0);
    check_eq("rst_mem_done", 32'(mem_done_o), 32'd0);
    check_eq("rst_if_data",  32'(if_data_o),  32'd0);
    check_eq("rst_mem_data", 32'(mem_data_o), 32'd0);

    // Both sides request at reset release: D wins first, I follows one slot later.
    if_request_i = 1'b1; if_addr_i = 32'h0;
    mem_request_i = 1'b1; mem_wr_i = 1'b0; mem_addr_i = 32'h200;
    @(negedge clk); rst = 1'b1;
    wait_done(1'b1, 8, n);
    check_eq("d_first_latency", 32'(n), 32'd3);
    check_eq("d_first_data", 32'(mem_data_o), 32'h5A);
    mem_request_i = 1'b0;
    wait_done(1'b0, 8, n);
    check_eq("i_second_gap", 32'(n), 32'd4);
    check_eq("i_second_data", 32'(if_data_o), 32'(init_val(0)));
    if_request_i = 1'b0;
    step(); step();

    // Plain I read of 0x100.
    if_request_i = 1'b1; if_addr_i = 32'h100;
    step();
    check_eq("i_read_addr", ram_addr_o, 32'h100);
    wait_done(1'b0, 8, n);
    check_eq("i_read_latency", 32'(n), 32'd2);
    check_eq("i_read_data", 32'(if_data_o), 32'h13);
    if_request_i = 1'b0;
    step(); step();

    // IO write held off while the buffer is full.
    io_buffer_full_i = 1'b1;
    mem_request_i = 1'b1; mem_wr_i = 1'b1; mem_addr_i = 32'h0003_0000; mem_data_i = 8'h41;
    repeat (5) begin
      step();
      check_eq("io_stall_wr", 32'(ram_wr_o), 32'd0);
    end
    io_buffer_full_i = 1'b0;
    step();
    check_eq("io_wr_strobe", 32'(ram_wr_o), 32'd1);
    check_eq("io_wr_addr", ram_addr_o, 32'h0003_0000);
    check_eq("io_wr_data", 32'(ram_dout_o), 32'h41);
    step();
    check_eq("io_wr_strobe_drop", 32'(ram_wr_o), 32'd0);
    step();
    check_eq("io_wr_done", 32'(mem_done_o), 32'd1);
    mem_request_i = 1'b0; mem_wr_i = 1'b0;
    step(); step();

    // Flush during WAIT cancels the I completion; next fetch proceeds.
    if_request_i = 1'b1; if_addr_i = 32'h8;
    step(); step();
    branch_error = 1'b1;
    step();
    check_eq("flush_no_done", 32'(if_done_o), 32'd0);
    branch_error = 1'b0; if_addr_i = 32'hC;
    step(); step();
    check_eq("flush_regrant_addr", ram_addr_o, 32'hC);
    wait_done(1'b0, 6, n);
    check_eq("flush_next_latency", 32'(n), 32'd2);
    check_eq("flush_next_data", 32'(if_data_o), 32'(init_val(ridx(32'hC))));
    if_request_i = 1'b0;
    step(); step();

    // Four-byte sequential fetch.
    if_request_i = 1'b1; if_addr_i = 32'h10; pulses = 0;
    for (int s = 0; s < 16; s++) begin
      step();
      if (s % 4 == 0) check_eq("fetch_addr", ram_addr_o, 32'h10 + 32'(s / 4));
      if (if_done_o) begin
        pulses++;
        if (pulses == 4) if_request_i = 1'b0;
        else if_addr_i = if_addr_i + 32'd1;
      end
    end
    check_eq("fetch_pulses", 32'(pulses), 32'd4);

    // Reset asserted while a D write is in ISSUE.
    step();
    mem_request_i = 1'b1; mem_wr_i = 1'b1; mem_addr_i = 32'h40; mem_data_i = 8'h77;
    step();
    #2; rst = 1'b0; #1;
    check_eq("rst_mid_wr", 32'(ram_wr_o), 32'd0);
    check_eq("rst_mid_addr", ram_addr_o, 32'd0);
    mem_request_i = 1'b0; mem_wr_i = 1'b0;
    step();
    @(negedge clk); rst = 1'b1;
    repeat (6) begin
      step();
      check_eq("rst_mid_no_done", 32'(mem_done_o), 32'd0);
    end

    // Randomized traffic from both sides with flushes and IO stalls.
    for (int c = 0; c < 3000; c++) begin
      step();
      if (mem_request_i && mem_done_o) mem_request_i = 1'b0;
      if (!mem_request_i && $urandom_range(0, 2) == 0) begin
        mem_request_i = 1'b1;
        mem_wr_i      = 1'($urandom_range(0, 1));
        mem_addr_i    = ($urandom_range(0, 5) == 0) ? IO_BASE + 32'($urandom_range(0, 3))
                                                    : 32'h20 + 32'($urandom_range(0, 15));
        mem_data_i    = 8'($urandom);
      end
      io_buffer_full_i = ($urandom_range(0, 2) == 0);
      if (if_done_o) begin
        if_addr_i = 32'h20 + ((if_addr_i + 32'd1) & 32'hF);
        if ($urandom_range(0, 3) == 0) if_request_i = 1'b0;
      end else if (!if_request_i && $urandom_range(0, 1) == 0) begin
        if_request_i = 1'b1;
      end
      branch_error = ($urandom_range(0, 9) == 0);
      if (branch_error) if_addr_i = 32'h20 + 32'($urandom_range(0, 15));
    end

    branch_error = 1'b0; if_request_i = 1'b0; mem_request_i = 1'b0;
    io_buffer_full_i = 1'b0;
    repeat (6) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
